// File: rtl/mult_sequencer.sv
// Multi-cycle MULT/MULTU sequencer: radix-2 shift-add over a shared external
// adder, with sign handling done on magnitudes and a final two's-complement fix.
module mult_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} stateT;

    stateT            state, nextState;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] opA, opB, mcand, accHi, accLo;
    logic             isSigned, neg;

    logic [WIDTH-1:0] absA, absB;
    logic [PW-1:0]    accFull, accFixed;
    logic             carry;

    // Magnitudes via internal negation; 0x80..0 maps to itself as an unsigned value
    assign absA     = (isSigned && opA[WIDTH-1]) ? (~opA + WIDTH'(1)) : opA;
    assign absB     = (isSigned && opB[WIDTH-1]) ? (~opB + WIDTH'(1)) : opB;
    assign accFull  = {accHi, accLo};
    assign accFixed = neg ? (~accFull + PW'(1)) : accFull;
    assign carry    = (add_sum < add_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = PREP;
            PREP:    nextState = ITER;
            ITER:    if (counter == CW'(WIDTH - 1)) nextState = FIX;
            FIX:     nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Adder operands are driven only while iterating so the adder is free otherwise
    always_comb begin
        add_a = '0;
        add_b = '0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE: ;
            PREP: busy = 1'b1;
            ITER: begin
                busy  = 1'b1;
                add_a = accHi;
                add_b = accLo[0] ? mcand : '0;
            end
            FIX:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter  <= '0;
            opA      <= '0;
            opB      <= '0;
            isSigned <= 1'b0;
            neg      <= 1'b0;
            mcand    <= '0;
            accHi    <= '0;
            accLo    <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opA      <= op_a;
                        opB      <= op_b;
                        isSigned <= is_signed;
                        neg      <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    end
                end
                PREP: begin
                    mcand   <= absA;
                    accHi   <= '0;
                    accLo   <= absB;
                    counter <= '0;
                end
                ITER: begin
                    // {carry, sum, accLo} >> 1
                    accHi   <= {carry, add_sum[WIDTH-1:1]};
                    accLo   <= {add_sum[0], accLo[WIDTH-1:1]};
                    counter <= counter + CW'(1);
                end
                FIX: begin
                    accHi <= accFixed[PW-1:WIDTH];
                    accLo <= accFixed[WIDTH-1:0];
                    hi    <= accFixed[PW-1:WIDTH];
                    lo    <= accFixed[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: models the external adder and checks
// products, done/busy timing, ignored starts, mid-run reset and back-to-back use.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a, op_b;
    logic [31:0] add_a, add_b, add_sum;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checkCount = 0;
    int errorCount = 0;
    logic [31:0] lastHi = '0;
    logic [31:0] lastLo = '0;

    mult_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // External combinational adder
    assign add_sum = add_a + add_b;

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One multiply from an IDLE cycle; injectAt >= 0 pulses a stray start mid-run
    task automatic runMul(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expHi,
                          input logic [31:0] expLo, input int injectAt);
        int   n;
        logic busyOk, holdOk;
        @(negedge clk);
        start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; is_signed = ~sgn; op_a = $urandom; op_b = $urandom;
        busyOk = busy;
        holdOk = 1'b1;
        n = 0;
        while (n < 60 && !done) begin
            if (n == injectAt) begin
                start = 1'b1; is_signed = 1'b1; op_a = 32'h1234_5678; op_b = 32'h8765_4321;
            end else if (n == injectAt + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (!busy) busyOk = 1'b0;
            if (!done && (hi !== lastHi || lo !== lastLo)) holdOk = 1'b0;
            if (n == 33) begin
                checkVal({tag, " fix add_a"}, 64'(add_a), 64'd0);
                checkVal({tag, " fix add_b"}, 64'(add_b), 64'd0);
            end
        end
        checkVal({tag, " latency"}, 64'(n), 64'd34);
        checkVal({tag, " hi"}, 64'(hi), 64'(expHi));
        checkVal({tag, " lo"}, 64'(lo), 64'(expLo));
        checkVal({tag, " busy span"}, 64'(busyOk), 64'd1);
        checkVal({tag, " hold"}, 64'(holdOk), 64'd1);
        @(posedge clk); #1;
        checkVal({tag, " done width"}, 64'(done), 64'd0);
        checkVal({tag, " busy end"}, 64'(busy), 64'd0);
        lastHi = expHi;
        lastLo = expLo;
    endtask

    initial begin
        logic doneSeen;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset busy", 64'(busy), 64'd0);
        checkVal("reset done", 64'(done), 64'd0);
        checkVal("reset hi", 64'(hi), 64'd0);
        checkVal("reset lo", 64'(lo), 64'd0);
        checkVal("reset add_a", 64'(add_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        runMul("multu 3x5", 1'b0, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, -1);
        runMul("multu ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        runMul("mult -2x3", 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1);
        runMul("mult min sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1);
        runMul("mult max x min", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, -1);
        runMul("mult -1x-1 stray start", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 5);

        // Reset with the iteration counter at 10 abandons the multiply
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op_a = 32'd1000; op_b = 32'd1000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkVal("midrst busy", 64'(busy), 64'd0);
        checkVal("midrst hi", 64'(hi), 64'd0);
        checkVal("midrst lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) doneSeen = 1'b1;
        end
        checkVal("midrst no done", 64'(doneSeen), 64'd0);
        lastHi = '0;
        lastLo = '0;

        runMul("multu 7x6", 1'b0, 32'd7, 32'd6, 32'h0, 32'd42, -1);
        runMul("back to back", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, -1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Multi-cycle controller for MIPS MULT/MULTU that time-shares one external 32-bit combinational adder (the core's Add block).
- Sequences a radix-2 shift-add multiply over the adder and produces the 64-bit HI/LO product.
- Sits beside the ALU in EX; the stall logic holds the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request a multiply; sampled only in IDLE.
- is_signed, input, 1, 1 = MULT (two's complement), 0 = MULTU; captured with start.
- op_a, input, WIDTH, multiplicand (rs); captured with start.
- op_b, input, WIDTH, multiplier (rt); captured with start.
- add_a, output, WIDTH, operand A to the external adder.
- add_b, output, WIDTH, operand B to the external adder.
- add_sum, input, WIDTH, sum returned by the external adder (combinational, same cycle).
- busy, output, 1, high whenever state is not IDLE.
- done, output, 1, one-cycle pulse; hi/lo are valid while it is high.
- hi, output, WIDTH, upper product word, registered.
- lo, output, WIDTH, lower product word, registered.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, counter=0, all internal registers=0, hi=0, lo=0, busy=0, done=0. A multiply in progress is abandoned and no done pulse is produced.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE -> PREP: on an edge with start=1.
  - Latch op_a, op_b, is_signed.
  - Latch neg = is_signed & (op_a[MSB] ^ op_b[MSB]).
- PREP -> ITER:
  - mcand = |op_a| and mplr = |op_b| when is_signed; raw operands otherwise. |x| = ~x+1 if x[MSB], computed by internal logic, not the shared adder.
  - acc_hi=0, acc_lo=mplr, counter=0.
  - |0x80000000| = 0x80000000, treated as an unsigned magnitude.
- ITER: exactly WIDTH edges, one per bit.
  - add_a=acc_hi; add_b = acc_lo[0] ? mcand : 0.
  - carry = (add_sum < add_a), unsigned compare.
  - {carry, add_sum, acc_lo} shifted right by 1 -> {acc_hi, acc_lo}.
  - counter increments each edge; on the edge where counter==WIDTH-1, go to FIX.
- Outside ITER, add_a=0 and add_b=0, so the adder is free for other uses.
- FIX -> DONE:
  - If neg, {acc_hi, acc_lo} is replaced by its 64-bit two's complement, using internal logic.
  - On this edge, hi<=acc_hi and lo<=acc_lo.
- DONE -> IDLE: unconditional. done=1 for exactly this cycle.
- Latency: start sampled at edge k -> done high after edge k+34 (WIDTH+2 edges), low after edge k+35.
- A new start is accepted no earlier than edge k+35, with the sequencer back in IDLE.
- busy=1 in PREP, ITER, FIX and DONE.
- start while busy is ignored; operands are not re-latched.
- hi/lo hold their last result until the next FIX->DONE edge; they never show intermediate values.
- Product = exact 2*WIDTH-bit product; no overflow is possible.

Test Plan:
- MULTU op_a=3, op_b=5 -> hi=0x00000000, lo=0x0000000F. done pulse is 1 cycle wide, exactly 34 cycles after the start edge. busy spans those 35 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Exercises the carry derived from add_sum < add_a.
- MULT -2 (0xFFFFFFFE) x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- During an active multiply, pulse start with new operands -> ignored; the original result and timing are unchanged. During FIX, add_a=add_b=0.
- Assert rst at ITER counter=10 -> busy=0, hi=lo=0, no done pulse. Then start 7 x 6 unsigned -> lo=42 after 34 cycles.
- Back-to-back: issue a start in the first IDLE cycle after done -> accepted. hi/lo keep the first result until the second done.
